usf_modulo_encoder: RTL and testbench

Iterative centered-modulo folding encoder: the transmit-side counterpart of the USF recovery path. It emulates a self-reset (modulo) ADC by folding a wide signed sample into [-LAMBDA, LAMBDA) and emits the folded ADC_RES-bit code, the signed fold count k (in = out + 2·LAMBDA·k), and an overflow flag. It generates stimulus and ground truth for the recovery datapath on the DE1-SoC, and can stand in for the modulo front end.

---
 rtl/usf_modulo_encoder_if.sv | 18 +
 rtl/usf_modulo_encoder.sv | 107 ++++++++++
 tb/tb_usf_modulo_encoder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/usf_modulo_encoder_if.sv
// Sample/result bus of the centered-modulo folding encoder.
// The master drives samples in; the slave returns folded code, fold count and overflow.
interface usf_modulo_encoder_if #(
   parameter int unsigned IN_RES  = 16,
   parameter int unsigned ADC_RES = 10,
   parameter int unsigned K_RES   = 5
);
   logic                      en;
   logic signed [IN_RES-1:0]  in;
   logic                      ready;
   logic signed [ADC_RES-1:0] out;
   logic signed [K_RES-1:0]   k;
   logic                      valid;
   logic                      ovf;

   modport master (output en, in, input ready, out, k, valid, ovf);
   modport slave  (input en, in, output ready, out, k, valid, ovf);
endinterface

// File: rtl/usf_modulo_encoder.sv
// Iterative centered-modulo folding encoder: folds a wide signed sample into
// [-LAMBDA, LAMBDA) one 2*LAMBDA step per cycle, reporting fold count and overflow.
module usf_modulo_encoder #(
   parameter int unsigned IN_RES    = 16,
   parameter int unsigned ADC_RES   = 10,
   parameter int          LAMBDA    = 256,
   parameter int          MAX_FOLDS = 15,
   parameter int unsigned K_RES     = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   usf_modulo_encoder_if.slave   bus
);
   // One guard bit so acc +/- 2*LAMBDA never wraps.
   localparam int unsigned ACC_W = IN_RES + 1;

   localparam logic signed [ACC_W-1:0]   POS_LAM = ACC_W'(LAMBDA);
   localparam logic signed [ACC_W-1:0]   NEG_LAM = ACC_W'(-LAMBDA);
   localparam logic signed [ACC_W-1:0]   TWO_LAM = ACC_W'(2 * LAMBDA);
   localparam logic signed [K_RES-1:0]   K_MAX   = K_RES'(MAX_FOLDS);
   localparam logic signed [K_RES-1:0]   K_MIN   = K_RES'(-MAX_FOLDS);
   localparam logic signed [ADC_RES-1:0] OUT_MAX = ADC_RES'(LAMBDA - 1);
   localparam logic signed [ADC_RES-1:0] OUT_MIN = ADC_RES'(-LAMBDA);

   typedef enum logic [0:0] {IDLE, FOLD} state_t;

   state_t                    state;
   logic signed [ACC_W-1:0]   acc;
   logic signed [K_RES-1:0]   kc;
   logic                      ready;
   logic                      valid;
   logic signed [ADC_RES-1:0] out;
   logic signed [K_RES-1:0]   k;
   logic                      ovf;

   logic above_c;
   logic below_c;
   logic can_fold_c;

   assign above_c    = (acc >= POS_LAM);
   assign below_c    = (acc < NEG_LAM);
   // |kc| < MAX_FOLDS; kc only ever moves in one direction per sample.
   assign can_fold_c = (kc < K_MAX) && (kc > K_MIN);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         ready <= 1'b1;
         valid <= 1'b0;
         out   <= '0;
         k     <= '0;
         ovf   <= 1'b0;
         acc   <= '0;
         kc    <= '0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.en) begin
                  acc   <= {bus.in[IN_RES-1], bus.in};
                  kc    <= '0;
                  ready <= 1'b0;
                  state <= FOLD;
               end
            end
            FOLD: begin
               if ((above_c || below_c) && can_fold_c) begin
                  if (above_c) begin
                     acc <= acc - TWO_LAM;
                     kc  <= kc + K_RES'(1);
                  end else begin
                     acc <= acc + TWO_LAM;
                     kc  <= kc - K_RES'(1);
                  end
               end else begin
                  // Either in range, or out of fold budget and saturating.
                  if (above_c) begin
                     out <= OUT_MAX;
                     ovf <= 1'b1;
                  end else if (below_c) begin
                     out <= OUT_MIN;
                     ovf <= 1'b1;
                  end else begin
                     out <= acc[ADC_RES-1:0];
                     ovf <= 1'b0;
                  end
                  k     <= kc;
                  valid <= 1'b1;
                  ready <= 1'b1;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ready = ready;
   assign bus.valid = valid;
   assign bus.out   = out;
   assign bus.k     = k;
   assign bus.ovf   = ovf;

endmodule

// File: tb/tb_usf_modulo_encoder.sv
// Self-checking bench for usf_modulo_encoder: directed corner cases plus random
// samples against a floor-division reference of the centered modulo.
module tb_usf_modulo_encoder;
   localparam int IN_RES    = 16;
   localparam int ADC_RES   = 10;
   localparam int LAMBDA    = 256;
   localparam int MAX_FOLDS = 15;
   localparam int K_RES     = 5;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   usf_modulo_encoder_if #(.IN_RES(IN_RES), .ADC_RES(ADC_RES), .K_RES(K_RES)) bus ();

   usf_modulo_encoder #(
      .IN_RES(IN_RES), .ADC_RES(ADC_RES), .LAMBDA(LAMBDA),
      .MAX_FOLDS(MAX_FOLDS), .K_RES(K_RES)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   int exp_out = 0;
   int exp_k   = 0;
   int exp_ovf = 0;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int floor_div(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q--;
      return q;
   endfunction

   // Centered modulo: k = floor((x + L) / 2L), out = x - 2L*k, saturate past the fold budget.
   task automatic model(input int x, output int o, output int kk, output int ov, output int lat);
      kk = floor_div(x + LAMBDA, 2 * LAMBDA);
      ov = 0;
      if (kk > MAX_FOLDS) begin
         kk = MAX_FOLDS; o = LAMBDA - 1; ov = 1;
      end else if (kk < -MAX_FOLDS) begin
         kk = -MAX_FOLDS; o = -LAMBDA; ov = 1;
      end else begin
         o = x - 2 * LAMBDA * kk;
      end
      lat = ov ? MAX_FOLDS + 1 : ((kk < 0) ? -kk : kk) + 1;
   endtask

   // Issue one sample at the current negedge; return at the negedge where valid is seen.
   task automatic run_sample(input int x, input string tag);
      int eo, ek, ev, lat, n;
      model(x, eo, ek, ev, lat);
      bus.en = 1'b1;
      bus.in = IN_RES'(x);
      @(negedge clk);
      bus.en = 1'b0;
      n = 1;
      chk({tag, "_busy_ready"}, int'(bus.ready), 0);
      chk({tag, "_held_out"}, int'(bus.out), exp_out);
      while (!bus.valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, n - 1, lat);
      chk({tag, "_out"}, int'(bus.out), eo);
      chk({tag, "_k"}, int'(bus.k), ek);
      chk({tag, "_ovf"}, int'(bus.ovf), ev);
      chk({tag, "_ready"}, int'(bus.ready), 1);
      exp_out = eo;
      exp_k   = ek;
      exp_ovf = ev;
   endtask

   task automatic idle_gap(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         chk({tag, "_idle_valid"}, int'(bus.valid), 0);
         chk({tag, "_idle_ready"}, int'(bus.ready), 1);
         chk({tag, "_idle_out"}, int'(bus.out), exp_out);
      end
   endtask

   initial begin
      int vcount;
      int x;

      // Reset with en held high: reset must win.
      bus.en = 1'b1;
      bus.in = IN_RES'(300);
      reset  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", int'(bus.ready), 1);
      chk("rst_valid", int'(bus.valid), 0);
      chk("rst_out", int'(bus.out), 0);
      chk("rst_k", int'(bus.k), 0);
      chk("rst_ovf", int'(bus.ovf), 0);
      bus.en = 1'b0;
      reset  = 1'b1;
      @(negedge clk);

      run_sample(100, "in100");
      idle_gap(3, "in100");
      run_sample(300, "in300");
      idle_gap(1, "in300");
      run_sample(-1000, "inm1000");
      idle_gap(1, "inm1000");
      run_sample(256, "in256");
      idle_gap(1, "in256");
      run_sample(-256, "inm256");
      idle_gap(1, "inm256");
      run_sample(32767, "in32767");
      idle_gap(1, "in32767");
      run_sample(5, "in5");
      idle_gap(1, "in5");
      run_sample(-32768, "inm32768");
      idle_gap(1, "inm32768");
      run_sample(255, "in255");
      idle_gap(1, "in255");
      run_sample(-257, "inm257");
      idle_gap(1, "inm257");

      // Busy-drop: a second en while folding must be ignored.
      bus.en = 1'b1;
      bus.in = IN_RES'(-1000);
      @(negedge clk);
      bus.in = IN_RES'(7);
      @(negedge clk);
      bus.en = 1'b0;
      vcount = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.valid) vcount++;
         @(negedge clk);
      end
      chk("busydrop_pulses", vcount, 1);
      chk("busydrop_out", int'(bus.out), 24);
      chk("busydrop_k", int'(bus.k), -2);
      exp_out = 24; exp_k = -2; exp_ovf = 0;

      // Reset abort mid-fold.
      bus.en = 1'b1;
      bus.in = IN_RES'(-1000);
      @(negedge clk);
      bus.en = 1'b0;
      reset  = 1'b0;
      @(negedge clk);
      chk("abort_valid", int'(bus.valid), 0);
      chk("abort_out", int'(bus.out), 0);
      chk("abort_k", int'(bus.k), 0);
      chk("abort_ready", int'(bus.ready), 1);
      reset  = 1'b1;
      vcount = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.valid) vcount++;
      end
      chk("abort_pulses", vcount, 0);
      exp_out = 0; exp_k = 0; exp_ovf = 0;

      // Back-to-back: next en issued in the valid cycle.
      run_sample(100, "b2b_first");
      run_sample(-5, "b2b_second");
      idle_gap(1, "b2b");

      for (int i = 0; i < 60; i++) begin
         if (i % 2 == 0) x = int'($urandom_range(1400, 0)) - 700;
         else            x = int'($signed(16'($urandom)));
         run_sample(x, $sformatf("rnd%0d", i));
         if ($urandom_range(1, 0) == 1) idle_gap(1, "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
